// File: rtl/mul_iter.sv
// mul_iter: iterative 32x32->64 integer multiplier for the RV32M multiply
// family (mul / mulh / mulhsu / mulhu). Each cycle it consumes BITS_PER_CYCLE
// bits of the multiplier magnitude, so latency is N+1 cycles from the sampled
// go to done, where N = 32/BITS_PER_CYCLE.
//
// Ports
//   clk    : clock
//   reset  : synchronous active-high reset
//   go     : request, level-sensitive; held high until done is consumed
//   sign0  : r is two's complement
//   sign1  : m is two's complement
//   m      : multiplicand (32)
//   r      : multiplier (32)
//   hold   : downstream stall; keeps DONE (and result) while go is also high
//   done   : result is valid for the current request
//   busy   : operation in progress (BUSY or DONE)
//   result : registered 64-bit product
module mul_iter #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        sign0,
    input  logic        sign1,
    input  logic [31:0] m,
    input  logic [31:0] r,
    input  logic        hold,
    output logic        done,
    output logic        busy,
    output logic [63:0] result
);

    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = 32 / K;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(K == 1 || K == 2 || K == 4 || K == 8 || K == 16 || K == 32)) begin : g_bad_k
            $error("mul_iter: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;
    logic [63:0]   m_sh;     // multiplicand magnitude, pre-shifted to the current digit weight
    logic [31:0]   r_sh;     // multiplier magnitude, low K bits are the current digit
    logic          neg;
    logic          last;
    logic [63:0]   pp;
    logic [63:0]   acc_sum;
    logic [31:0]   mag_m;
    logic [31:0]   mag_r;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign mag_m = (sign1 && m[31]) ? (~m + 32'd1) : m;
    assign mag_r = (sign0 && r[31]) ? (~r + 32'd1) : r;

    assign last    = (cnt == CW'(N - 1));
    assign pp      = m_sh * {{(64 - K){1'b0}}, r_sh[K-1:0]};
    assign acc_sum = acc + pp;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (go) state_nxt = S_BUSY;
            S_BUSY: begin
                // Dropping go aborts, even on the final iteration.
                if (!go)       state_nxt = S_IDLE;
                else if (last) state_nxt = S_DONE;
            end
            S_DONE: if (!(hold && go)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            m_sh   <= '0;
            r_sh   <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        m_sh <= {32'd0, mag_m};
                        r_sh <= mag_r;
                        neg  <= (sign1 & m[31]) ^ (sign0 & r[31]);
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    if (go) begin
                        acc  <= acc_sum;
                        m_sh <= m_sh << K;
                        r_sh <= r_sh >> K;
                        cnt  <= cnt + CW'(1);
                        if (last) result <= neg ? (~acc_sum + 64'd1) : acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
module tb_mul_iter;

    localparam int ND = 6;   // DUT g uses BITS_PER_CYCLE = 1 << g
    localparam int D4 = 2;   // index of the K=4 instance

    logic        clk = 1'b0;
    logic        reset, go, sign0, sign1, hold;
    logic [31:0] m, r;
    logic        done_v [ND];
    logic        busy_v [ND];
    logic [63:0] res_v  [ND];

    int          npass = 0;
    int          ntotal = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mul_iter #(.BITS_PER_CYCLE(1 << g)) u_dut (
            .clk   (clk),
            .reset (reset),
            .go    (go),
            .sign0 (sign0),
            .sign1 (sign1),
            .m     (m),
            .r     (r),
            .hold  (hold),
            .done  (done_v[g]),
            .busy  (busy_v[g]),
            .result(res_v[g])
        );
    end

    // Reference: sign/zero-extend both operands to 64 bits and multiply mod 2^64.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s0, input logic s1);
        logic [63:0] x, y;
        x = s1 ? {{32{a[31]}}, a} : {32'd0, a};
        y = s0 ? {{32{b[31]}}, b} : {32'd0, b};
        return x * y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request on all instances with shared inputs.
    // hld=1: go and hold stay high, so every instance parks in DONE.
    // hld=0: each instance is checked only up to the cycle after its done pulse.
    // chg=1: operands and signs are scrambled after the capture cycle.
    task automatic sweep(input logic [31:0] am, input logic [31:0] ar, input logic as0,
                         input logic as1, input bit hld, input bit chg);
        logic [63:0] exp;
        exp   = ref_mul(am, ar, as0, as1);
        m     = am;
        r     = ar;
        sign0 = as0;
        sign1 = as1;
        hold  = hld;
        go    = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            for (int g = 0; g < ND; g++) begin
                int n;
                n = 32 >> g;
                if (hld) begin
                    chk($sformatf("k%0d c%0d done", 1 << g, c), 64'(done_v[g]), 64'(c >= n + 1));
                    chk($sformatf("k%0d c%0d busy", 1 << g, c), 64'(busy_v[g]), 64'd1);
                    if (c >= n + 1) chk($sformatf("k%0d c%0d result", 1 << g, c), res_v[g], exp);
                end else if (c <= n + 2) begin
                    chk($sformatf("k%0d c%0d done", 1 << g, c), 64'(done_v[g]), 64'(c == n + 1));
                    chk($sformatf("k%0d c%0d busy", 1 << g, c), 64'(busy_v[g]), 64'(c <= n + 1));
                    if (c == n + 1) chk($sformatf("k%0d c%0d result", 1 << g, c), res_v[g], exp);
                end
            end
            if (chg && c == 1) begin
                m     = 32'd0;
                r     = 32'd0;
                sign0 = ~as0;
                sign1 = ~as1;
            end
        end
        go   = 1'b0;
        hold = 1'b0;
        tick();
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("k%0d idle busy", 1 << g), 64'(busy_v[g]), 64'd0);
            chk($sformatf("k%0d idle done", 1 << g), 64'(done_v[g]), 64'd0);
        end
        tick();
        last_res = exp;
    endtask

    initial begin
        logic [63:0] prev, exp_a, exp_b;
        logic [31:0] bm, br;
        logic        bs0, bs1;

        reset = 1'b1; go = 1'b0; hold = 1'b0;
        sign0 = 1'b0; sign1 = 1'b0; m = '0; r = '0;
        tick();
        tick();
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("k%0d reset done", 1 << g), 64'(done_v[g]), 64'd0);
            chk($sformatf("k%0d reset busy", 1 << g), 64'(busy_v[g]), 64'd0);
            chk($sformatf("k%0d reset result", 1 << g), res_v[g], 64'd0);
        end
        reset = 1'b0;
        tick();

        // Directed sweeps across every K.
        sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        sweep(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        sweep(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0);
        sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);

        // Randomized sweeps.
        for (int i = 0; i < 6; i++) begin
            sweep($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'b1, 1'($urandom_range(0, 1)));
        end

        // Abort on K=4: go low in cycle 4, new request sampled in cycle 6.
        prev  = last_res;
        m     = $urandom; r = $urandom;
        sign0 = 1'($urandom_range(0, 1)); sign1 = 1'($urandom_range(0, 1));
        bm    = $urandom; br = $urandom;
        bs0   = 1'($urandom_range(0, 1)); bs1 = 1'($urandom_range(0, 1));
        exp_b = ref_mul(bm, br, bs0, bs1);
        hold  = 1'b0;
        go    = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("abort c%0d done", c), 64'(done_v[D4]), 64'(c == 15));
            chk($sformatf("abort c%0d busy", c), 64'(busy_v[D4]),
                64'((c <= 4) || (c >= 7 && c <= 15)));
            chk($sformatf("abort c%0d result", c), res_v[D4], (c >= 15) ? exp_b : prev);
            if (c == 4) go = 1'b0;
            if (c == 6) begin
                m = bm; r = br; sign0 = bs0; sign1 = bs1;
                go = 1'b1;
            end
        end
        go = 1'b0;
        tick();
        tick();

        // Hold for 3 cycles from cycle 9, then 7x6 back-to-back on K=4.
        m     = $urandom; r = $urandom;
        sign0 = 1'($urandom_range(0, 1)); sign1 = 1'($urandom_range(0, 1));
        exp_a = ref_mul(m, r, sign0, sign1);
        prev  = exp_b;
        go    = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            chk($sformatf("hold c%0d done", c), 64'(done_v[D4]),
                64'((c >= 9 && c <= 12) || c == 22));
            chk($sformatf("hold c%0d busy", c), 64'(busy_v[D4]), 64'(c != 13 && c != 23));
            chk($sformatf("hold c%0d result", c), res_v[D4],
                (c < 9) ? prev : ((c < 22) ? exp_a : 64'd42));
            if (c == 9) hold = 1'b1;
            if (c == 12) begin
                hold  = 1'b0;
                m     = 32'd7;
                r     = 32'd6;
                sign0 = 1'($urandom_range(0, 1));
                sign1 = 1'($urandom_range(0, 1));
            end
        end
        go = 1'b0;
        tick();
        tick();

        // Reset in cycle 5 of an operation.
        m  = $urandom; r = $urandom;
        go = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) begin
                for (int g = 0; g < ND; g++) begin
                    chk($sformatf("k%0d midreset done", 1 << g), 64'(done_v[g]), 64'd0);
                    chk($sformatf("k%0d midreset busy", 1 << g), 64'(busy_v[g]), 64'd0);
                    chk($sformatf("k%0d midreset result", 1 << g), res_v[g], 64'd0);
                end
            end
            if (c == 5) reset = 1'b1;
        end
        reset = 1'b0;
        go    = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative 32×32→64 integer multiplier serving the execute stage's multiply handshake (`go`/`done`) for RV32M `mul`, `mulh`, `mulhsu` and `mulhu`. The execute stage holds `go` high with stable operands and stalls until `done`. It then picks `result[31:0]` or `result[63:32]`. The block retires `BITS_PER_CYCLE` multiplier bits per cycle, so throughput trades against area. A `hold` input keeps the completed result presented while the downstream pipeline is stalled.

## Interface
- `BITS_PER_CYCLE`, default 4: multiplier bits consumed per iteration. Legal values are 1, 2, 4, 8, 16 and 32; any other value is an elaboration error. N = 32/`BITS_PER_CYCLE`.
- `clk`  in  1  clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  operation request, level-sensitive. The initiator holds it high until it consumes `done`.
- `sign0`  in  1  `r` is signed (two's complement).
- `sign1`  in  1  `m` is signed (two's complement).
- `m`  in  32  multiplicand, from rs1 or the pc.
- `r`  in  32  multiplier, from rs2 or the immediate.
- `hold`  in  1  downstream stall. While `done` is high, the DONE state is held.
- `done`  out  1  `result` is valid for the current request.
- `busy`  out  1  an operation is in progress, in BUSY or DONE.
- `result`  out  64  full product, registered.

## Operation
- States are IDLE, BUSY and DONE. Reset forces IDLE with `done`=0, `busy`=0, `result`=0, iteration count 0 and accumulator 0.
- **IDLE**: on `go`=1, capture the operands:
  - `mag_m` = |m| if `sign1`, else m.
  - `mag_r` = |r| if `sign0`, else r.
  - `neg` = (`sign1`&m[31]) ^ (`sign0`&r[31]).
  - Clear the accumulator and count, then go to BUSY.
  - Magnitudes are 32-bit unsigned. |0x80000000| = 0x80000000 with no overflow.
- **BUSY**, once per cycle:
  - acc += `mag_m` × `mag_r`[K-1:0] << (K·count), where K = `BITS_PER_CYCLE`. Equivalently, shift `mag_r` right by K each cycle.
  - The accumulator is 64 bits unsigned and never overflows.
  - count increments. After iteration N (count == N-1), load `result` = `neg` ? −acc : acc, taken mod 2^64, and go to DONE.
- **DONE**: `done`=1.
  - If `hold`=1 and `go`=1, stay in DONE with `result` stable.
  - Otherwise go to IDLE. `go` high in the following IDLE cycle is treated as a new request.
- **Abort**: `go`=0 in BUSY or DONE returns to IDLE on the next edge. No `done` is produced and `result` keeps its previous value.
- Operand and sign changes after the IDLE capture cycle are ignored.
- `busy` = (state ≠ IDLE). `done` = (state == DONE). Both are decoded from registered state, with no combinational path from inputs.
- `result` changes only on entry to DONE or on reset.

## Timing
- The IDLE cycle that samples `go`=1 is cycle 0. Cycles 1..N are BUSY and cycle N+1 is the first DONE cycle.
- Latency from `go` to `done` is N+1 cycles: 9 for K=4, 33 for K=1, 2 for K=32.
- Without `hold`, `done` is high for exactly 1 cycle.
- Back-to-back operation: DONE, then IDLE (capture), then BUSY. The minimum spacing between `done` pulses is N+2 cycles.
- `hold` is ignored outside DONE.
- `reset` wins over all other inputs in any state. The in-flight operation is dropped and all outputs return to their reset values on the next edge.
- If `go` falls in the same cycle the last iteration completes, the block enters IDLE, `result` is not updated, and `done` is never asserted.

## Test plan
- **Unsigned**: K=4, `go`=1, m=r=0xFFFFFFFF, `sign0`=`sign1`=0 → `done` high in cycle 9 only, `result`=0xFFFFFFFE00000001, `busy` high in cycles 1–9.
- **Signed extremes**: m=r=0x80000000, both signs set → `result`=0x4000000000000000. m=0x80000000, r=0x00000001, both signed → `result`=0xFFFFFFFF80000000.
- **Mixed (mulhsu)**: m=0xFFFFFFFF with `sign1`=1, r=0xFFFFFFFF with `sign0`=0 → `result`=0xFFFFFFFF00000001. Operands are changed to 0 during BUSY and the result is unaffected.
- **Abort**: `go` drops in cycle 4 → `busy`=0 in cycle 5, `done` never rises, `result` is unchanged. `go` reasserted in cycle 6 → `done` in cycle 15.
- **Hold and back-to-back**:
  - `hold`=1 for 3 cycles from cycle 9 → `done` high in cycles 9–12, `result` stable.
  - New operands 7×6 with `go` held, first sampled in cycle 13 → `done` in cycle 22 with `result`=42.
- **Reset and parameter sweep**:
  - `reset` in cycle 5 of an operation → the next cycle shows `done`=0, `busy`=0, `result`=0.
  - Repeat the first three scenarios for K=1, 2, 8, 16 and 32, checking latencies of 33, 17, 5, 3 and 2 cycles.
